ha_array_accumulator: RTL and testbench
=======================================

Name: ha_array_accumulator

Overview:
- Consumer side of the 8x8 half-adder partial-product array interface: accepts the four row pairs (b, t) produced by a ha_array generator and reduces them to the final unsigned product.
- Multi-cycle: one row per clock, one 17-bit adder, saturated 16-bit result with overflow flag.
- Sits between the approximate partial-product generator and downstream datapath registers; valid/ready on both sides.

Parameters:
- ROWS, 4, number of row pairs (fixed at 4 for 8x8; other values unsupported)
- OUT_W, 16, product width
- ACC_W, 17, internal accumulator width (must cover max row sum 86615)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  row bundle valid
- in_ready  output  1  block can accept bundle
- ha_array_0_b  input  7  row 0 carry bits
- ha_array_0_t  input  9  row 0 sum bits
- ha_array_1_b / ha_array_1_t  input  7 / 9  row 1
- ha_array_2_b / ha_array_2_t  input  7 / 9  row 2
- ha_array_3_b / ha_array_3_t  input  7 / 9  row 3
- out_valid  output  1  product valid
- out_ready  input  1  downstream accepts product
- product  output  16  saturated product
- overflow  output  1  accumulated sum exceeded 65535 (valid with out_valid)

Behaviour:
- Weights, row i (0..3): t[k] weight 2^(2i+k); b[j] weight 2^(2i+j+2). Row term R_i = (t_i << 2i) + (b_i << (2i+2)), zero-extended to ACC_W.
- Reset (async, rst_n=0): state=IDLE, row counter=0, acc=0, captured rows=0, in_ready=0 during reset then 1 in IDLE, out_valid=0, product=0, overflow=0.
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=1. On in_valid: capture all 8 buses into holding registers, acc<=0, cnt<=0, go to ACCUM.
- ACCUM: in_ready=0. Each cycle acc<=acc+R_cnt, cnt<=cnt+1. After cnt=3 add, go to DONE. Exactly 4 cycles in ACCUM.
- DONE: out_valid=1; product = (acc>65535) ? 16'hFFFF : acc[15:0]; overflow = acc[16] | (acc>65535). Product/overflow registered, stable while out_valid=1 and out_ready=0.
- DONE handshake: out_ready=1 completes transfer. in_ready=out_ready in DONE; if in_valid&out_ready same cycle, capture new bundle and go directly to ACCUM (no IDLE bubble); else out_ready -> IDLE.
- Latency: accept at edge N -> out_valid high after edge N+4; throughput one product per 5 cycles when back-to-back.
- Inputs ignored whenever in_ready=0; changing buses during ACCUM has no effect.
- Accumulator never wraps: ACC_W=17 holds max 86615.
- rst_n asserted mid-ACCUM or in DONE: immediate return to reset values; partial sum discarded, no out_valid.

Test Plan:
- Reset then all buses 0, in_valid pulse -> out_valid after 4 ACCUM cycles, product=0, overflow=0.
- Row 0 t=9'h001, rest 0 -> product=1; row 2 t=9'h100 only -> product=4096; row 3 b=7'h40 only -> product=16384.
- All row buses all-ones -> acc=86615, product=16'hFFFF, overflow=1.
- out_ready held low 10 cycles in DONE -> product/out_valid stable, in_ready=0; inputs changed meanwhile ignored; release -> single transfer.
- Back-to-back: in_valid held with new bundle (row 1 t=9'h003 -> product 12) while out_ready=1 in DONE -> new capture same cycle, next result 5 cycles later, no IDLE cycle.
- rst_n low during 2nd ACCUM cycle -> out_valid=0, product=0 immediately; after release in_ready=1, next bundle computes correctly.

Source files
------------

// File: rtl/ha_array_accumulator.sv
// Reduces the four (b, t) row pairs of the 8x8 half-adder array into a saturated
// 16-bit unsigned product, one row per clock through a single ACC_W-bit adder.
module ha_array_accumulator #(
    parameter int ROWS  = 4,
    parameter int OUT_W = 16,
    parameter int ACC_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       ha_array_0_b,
    input  logic [8:0]       ha_array_0_t,
    input  logic [6:0]       ha_array_1_b,
    input  logic [8:0]       ha_array_1_t,
    input  logic [6:0]       ha_array_2_b,
    input  logic [8:0]       ha_array_2_t,
    input  logic [6:0]       ha_array_3_b,
    input  logic [8:0]       ha_array_3_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [ROWS-1:0][8:0]   t_q, t_d;
    logic [ROWS-1:0][6:0]   b_q, b_d;
    logic [OUT_W-1:0]       product_q, product_d;
    logic                   overflow_q, overflow_d;

    logic [ROWS-1:0][8:0]   t_in;
    logic [ROWS-1:0][6:0]   b_in;
    logic [ACC_W-1:0]       row_term;
    logic [ACC_W-1:0]       acc_sum;
    logic [3:0]             t_sh;
    logic                   capture;

    assign t_in = {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};
    assign b_in = {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};

    // Row i: t weighted 2^(2i), b weighted 2^(2i+2).
    assign t_sh     = {1'b0, cnt_q, 1'b0};
    assign row_term = (ACC_W'(t_q[cnt_q]) << t_sh) + (ACC_W'(b_q[cnt_q]) << (t_sh + 4'd2));
    assign acc_sum  = acc_q + row_term;

    // Held low while reset is asserted; in DONE a new bundle rides on the output transfer.
    assign in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign capture  = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        t_d        = t_q;
        b_d        = b_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    t_d     = t_in;
                    b_d     = b_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d    = DONE;
                    overflow_d = |acc_sum[ACC_W-1:OUT_W];
                    product_d  = (|acc_sum[ACC_W-1:OUT_W]) ? '1 : acc_sum[OUT_W-1:0];
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (capture) begin
                        t_d     = t_in;
                        b_d     = b_in;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            t_q        <= '0;
            b_q        <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            t_q        <= t_d;
            b_q        <= b_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign product   = product_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Directed bench for ha_array_accumulator: table of row bundles with hand-computed
// products, plus stall, back-to-back and mid-accumulation reset sequences.
module tb_ha_array_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  b0 = '0, b1 = '0, b2 = '0, b3 = '0;
    logic [8:0]  t0 = '0, t1 = '0, t2 = '0, t3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ha_array_accumulator dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ha_array_0_b(b0), .ha_array_0_t(t0),
        .ha_array_1_b(b1), .ha_array_1_t(t1),
        .ha_array_2_b(b2), .ha_array_2_t(t2),
        .ha_array_3_b(b3), .ha_array_3_t(t3),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .overflow(overflow)
    );

    typedef struct {
        logic [3:0][6:0] b;
        logic [3:0][8:0] t;
        logic [15:0]     p;
        logic            o;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        b0 = v.b[0]; b1 = v.b[1]; b2 = v.b[2]; b3 = v.b[3];
        t0 = v.t[0]; t1 = v.t[1]; t2 = v.t[2]; t3 = v.t[3];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until out_valid rises; called right after the accept edge.
    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        chk({name, " latency"}, cycles, 4);
    endtask

    task automatic run_vec(input int i);
        int cyc;
        chk($sformatf("v%0d in_ready idle", i), in_ready, 1);
        drive(vecs[i]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk($sformatf("v%0d in_ready accum", i), in_ready, 0);
        wait_done($sformatf("v%0d", i), cyc);
        chk($sformatf("v%0d product", i), product, vecs[i].p);
        chk($sformatf("v%0d overflow", i), overflow, vecs[i].o);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk($sformatf("v%0d out_valid drop", i), out_valid, 0);
    endtask

    initial begin
        vec_t v;
        int   cyc;
        logic [15:0] held;

        for (int i = 0; i < 8; i++) begin
            vecs[i].b = '0; vecs[i].t = '0; vecs[i].p = '0; vecs[i].o = 1'b0;
        end
        vecs[1].t[0] = 9'h001;  vecs[1].p = 16'd1;
        vecs[2].t[2] = 9'h100;  vecs[2].p = 16'd4096;
        vecs[3].b[3] = 7'h40;   vecs[3].p = 16'd16384;
        vecs[4].b = {4{7'h7F}}; vecs[4].t = {4{9'h1FF}}; vecs[4].p = 16'hFFFF; vecs[4].o = 1'b1;
        // 127*4 + 511*4 = 2552
        vecs[5].b[0] = 7'h7F;   vecs[5].t[1] = 9'h1FF; vecs[5].p = 16'd2552;
        // Row 3 full = 65216; +319 lands exactly on 65535, +320 just over
        vecs[6].b[3] = 7'h7F; vecs[6].t[3] = 9'h1FF; vecs[6].t[0] = 9'h13F; vecs[6].p = 16'hFFFF; vecs[6].o = 1'b0;
        vecs[7].b[3] = 7'h7F; vecs[7].t[3] = 9'h1FF; vecs[7].t[0] = 9'h140; vecs[7].p = 16'hFFFF; vecs[7].o = 1'b1;

        #12;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset product", product, 0);
        chk("reset overflow", overflow, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(i);

        // Stall in DONE for 10 cycles with inputs wiggling.
        drive(vecs[5]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done("stall", cyc);
        chk("stall product", product, 16'd2552);
        held = product;
        for (int k = 0; k < 10; k++) begin
            drive(vecs[4]);
            in_valid = (k % 2) == 0;
            tick();
            chk("stall out_valid", out_valid, 1);
            chk("stall product hold", product, held);
            chk("stall in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall released", out_valid, 0);
        tick();
        chk("stall single xfer", out_valid, 0);
        chk("stall back to idle", in_ready, 1);

        // Back-to-back: new bundle accepted on the same edge as the transfer.
        drive(vecs[4]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done("b2b first", cyc);
        chk("b2b first product", product, 16'hFFFF);
        v.b = '0; v.t = '0; v.t[1] = 9'h003;
        drive(v);
        chk("b2b in_ready follows out_ready", in_ready, 0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("b2b in_ready in done", in_ready, 1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b no idle out_valid", out_valid, 0);
        chk("b2b no idle in_ready", in_ready, 0);
        wait_done("b2b second", cyc);
        chk("b2b second product", product, 16'd12);
        chk("b2b second overflow", overflow, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during the second ACCUM cycle.
        drive(vecs[4]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst product", product, 0);
        chk("midrst in_ready", in_ready, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("midrst held", out_valid, 0);
        end
        rst_n = 1'b1;
        tick();
        chk("midrst in_ready after", in_ready, 1);
        run_vec(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
